// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: owns the PC, sequences instruction-memory reads
// over a ready handshake and resolves ID/EX redirects by priority.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        branch_e,
  input  logic        jalr_e,
  input  logic        jal_d,
  input  logic [31:0] branch_target,
  input  logic [31:0] jalr_target,
  input  logic [31:0] jal_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  output logic [31:0] pc_f,
  output logic        valid_f,
  output logic        flush_d,
  output logic        flush_e,
  output logic        misalign
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_DRAIN
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_tgt_q;
  logic        r_req;
  logic        r_misalign;

  logic        w_redir;
  logic [31:0] w_tgt_raw;
  logic [31:0] w_tgt;

  // Redirect priority: EX requests are older than the ID jal.
  always_comb begin
    w_redir   = branch_e | jalr_e | jal_d;
    w_tgt_raw = '0;
    if (branch_e)    w_tgt_raw = branch_target;
    else if (jalr_e) w_tgt_raw = jalr_target;
    else if (jal_d)  w_tgt_raw = jal_target;
    w_tgt = {w_tgt_raw[31:2], 2'b00};
  end

  // Fetch sequencing: PC, pending redirect target and request strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_PC;
      r_tgt_q <= '0;
      r_req   <= 1'b0;
    end else begin
      case (r_state)
        S_BOOT: begin
          if (w_redir) r_pc <= w_tgt;
          r_req   <= 1'b1;
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (w_redir) begin
            if (imem_ready) begin
              r_pc <= w_tgt;
            end else begin
              // Address must stay stable until the outstanding read completes.
              r_tgt_q <= w_tgt;
              r_state <= S_DRAIN;
            end
          end else if (imem_ready && !stall_f) begin
            r_pc <= r_pc + 32'd4;
          end
        end
        S_DRAIN: begin
          if (imem_ready) begin
            r_pc    <= w_redir ? w_tgt : r_tgt_q;
            r_state <= S_FETCH;
          end else if (w_redir) begin
            r_tgt_q <= w_tgt;
          end
        end
        default: begin
          r_state <= S_BOOT;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flag for any selected redirect target that is not word aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_misalign <= 1'b0;
    else if (w_redir && (w_tgt_raw[1:0] != 2'b00)) r_misalign <= 1'b1;
  end

  // Output decode; flushes and valid depend on this cycle's inputs.
  always_comb begin
    imem_req  = r_req;
    imem_addr = r_pc;
    pc_f      = r_pc;
    valid_f   = (r_state == S_FETCH) & imem_ready & ~w_redir;
    flush_e   = branch_e | jalr_e;
    flush_d   = branch_e | jalr_e | jal_d;
    misalign  = r_misalign;
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: each driven cycle pushes its expected
// outputs, which are popped and compared on the following falling edge.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_f, branch_e, jalr_e, jal_d;
  logic [31:0] branch_target, jalr_target, jal_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] pc_f;
  logic        valid_f, flush_d, flush_e, misalign;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_cyc    = 0;

  typedef struct {
    int unsigned cyc;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic        fd;
    logic        fe;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall_f(stall_f),
    .branch_e(branch_e), .jalr_e(jalr_e), .jal_d(jal_d),
    .branch_target(branch_target), .jalr_target(jalr_target), .jal_target(jal_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .pc_f(pc_f), .valid_f(valid_f), .flush_d(flush_d), .flush_e(flush_e),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, push its expectation, compare on negedge.
  task automatic step(input logic rel, input logic stall, input logic br, input logic jr,
                      input logic jl, input logic [31:0] bt, input logic [31:0] jrt,
                      input logic [31:0] jlt, input logic rdy, input logic ereq,
                      input logic [31:0] eaddr, input logic ev, input logic efd,
                      input logic efe, input logic emis);
    exp_t e;
    exp_t g;
    @(posedge clk);
    #1;
    if (rel) rst = 1'b0;
    stall_f = stall; branch_e = br; jalr_e = jr; jal_d = jl;
    branch_target = bt; jalr_target = jrt; jal_target = jlt; imem_ready = rdy;
    e.cyc = n_cyc; e.req = ereq; e.addr = eaddr; e.valid = ev;
    e.fd = efd; e.fe = efe; e.mis = emis;
    exp_q.push_back(e);
    n_cyc++;
    @(negedge clk);
    g = exp_q.pop_front();
    chk($sformatf("c%0d_req", g.cyc), {31'b0, imem_req}, {31'b0, g.req});
    chk($sformatf("c%0d_addr", g.cyc), imem_addr, g.addr);
    chk($sformatf("c%0d_pc_f", g.cyc), pc_f, g.addr);
    chk($sformatf("c%0d_valid", g.cyc), {31'b0, valid_f}, {31'b0, g.valid});
    chk($sformatf("c%0d_flush_d", g.cyc), {31'b0, flush_d}, {31'b0, g.fd});
    chk($sformatf("c%0d_flush_e", g.cyc), {31'b0, flush_e}, {31'b0, g.fe});
    chk($sformatf("c%0d_misalign", g.cyc), {31'b0, misalign}, {31'b0, g.mis});
  endtask

  initial begin
    rst = 1'b1; stall_f = 0; branch_e = 0; jalr_e = 0; jal_d = 0;
    branch_target = '0; jalr_target = '0; jal_target = '0; imem_ready = 1'b1;
    repeat (2) @(posedge clk);

    // rel stl br jr jl  bt  jrt jlt  rdy | req addr valid fd fe mis
    step(1, 0, 0, 0, 0, 0, 0, 0, 1,  0, 32'h0,   0, 0, 0, 0);  // BOOT
    step(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 32'h0,   1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 32'h4,   1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 1,  1, 32'h8,   1, 0, 0, 0);  // stall
    step(0, 1, 0, 0, 0, 0, 0, 0, 1,  1, 32'h8,   1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 32'h8,   1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 32'hC,   1, 0, 0, 0);
    // branch and jal together: branch wins
    step(0, 0, 1, 0, 1, 32'h100, 0, 32'h200, 1,  1, 32'h10, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0, 0, 32'h20, 1,         1, 32'h100, 0, 1, 0, 0);
    // ready low with jalr mid-wait: address held, drained target taken
    step(0, 0, 0, 0, 0, 0, 0, 0, 0,              1, 32'h20, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 32'h80, 0, 0,         1, 32'h20, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0,              1, 32'h20, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1,              1, 32'h20, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1,              1, 32'h80, 1, 0, 0, 0);
    // latest redirect during DRAIN wins
    step(0, 0, 1, 0, 0, 32'h300, 0, 0, 0,        1, 32'h84, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0, 0, 32'h400, 0,        1, 32'h84, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1,              1, 32'h84, 0, 0, 0, 0);
    // redirect coinciding with the DRAIN completion beats tgt_q
    step(0, 0, 0, 0, 1, 0, 0, 32'h500, 0,        1, 32'h400, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0, 32'h600, 0, 0, 1,        1, 32'h400, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1,              1, 32'h600, 1, 0, 0, 0);
    // redirect overrides stall
    step(0, 1, 0, 0, 1, 0, 0, 32'h700, 1,        1, 32'h604, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1,              1, 32'h700, 1, 0, 0, 0);
    // misaligned jal target
    step(0, 0, 0, 0, 1, 0, 0, 32'h42, 1,         1, 32'h704, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1,              1, 32'h40, 1, 0, 0, 1);
    // wrap at top of address space
    step(0, 0, 0, 1, 0, 0, 32'hFFFF_FFFC, 0, 1,  1, 32'h44, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1,              1, 32'hFFFF_FFFC, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1,              1, 32'h0, 1, 0, 0, 1);

    // reset while a request is outstanding
    @(posedge clk);
    #1;
    imem_ready = 1'b0; jal_d = 0; jalr_e = 0; branch_e = 0;
    #1;
    chk("pre_rst_req", {31'b0, imem_req}, 32'd1);
    chk("pre_rst_addr", imem_addr, 32'h4);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_req_drop", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_misalign", {31'b0, misalign}, 32'd0);
    chk("rst_valid", {31'b0, valid_f}, 32'd0);
    repeat (2) @(posedge clk);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1,              0, 32'h0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1,              1, 32'h0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1,              1, 32'h4, 1, 0, 0, 0);

    // redirect during BOOT
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    step(1, 0, 0, 0, 1, 0, 0, 32'h1000, 1,       0, 32'h0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1,              1, 32'h1000, 1, 0, 0, 0);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Fetch-stage controller: owns the PC register, sequences instruction-memory reads over a ready handshake, and resolves redirect requests from the ID stage (jal) and the EX stage (branch, jalr) by priority.
- Produces IF/ID and ID/EX flush strobes.
- Sits between the hazard unit, the instruction memory and the IF/ID pipeline register.
- Supports multi-cycle memory latency without breaking address stability.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous, active-high reset
- stall_f  input  1  hazard unit: hold IF/ID, do not advance PC
- branch_e  input  1  EX branch taken
- jalr_e  input  1  EX jalr
- jal_d  input  1  ID jal
- branch_target  input  32  branch target
- jalr_target  input  32  jalr target
- jal_target  input  32  jal target
- imem_req  output  1  read request
- imem_addr  output  32  read address
- imem_ready  input  1  read data valid this cycle
- pc_f  output  32  PC of instruction presented to IF/ID
- valid_f  output  1  instruction at pc_f is valid this cycle
- flush_d  output  1  clear IF/ID
- flush_e  output  1  clear ID/EX
- misalign  output  1  sticky: a redirect target had bits[1:0] != 0

Behaviour:
- Reset is asynchronous and active-high. The clock port is named clk; the reset port is named rst.
- Reset values:
  - state=BOOT, pc=RESET_PC, tgt_q=0, misalign=0
  - imem_req=0, valid_f=0, flush_d=0, flush_e=0
- Redirect selection (combinational): branch_e > jalr_e > jal_d. EX requests are older, so jal_d is ignored when either EX request is set.
  - redir = branch_e|jalr_e|jal_d; tgt = selected target with bits[1:0] forced to 0.
  - Any selected target with nonzero bits[1:0] sets misalign (cleared only by rst).
- Flushes (combinational, same cycle as request):
  - flush_e = branch_e|jalr_e
  - flush_d = branch_e|jalr_e|jal_d
  - Flushes assert regardless of stall_f or state.
- imem_addr = pc; pc_f = pc.
- Address-stability rule: once imem_req=1, imem_addr must not change until a cycle with imem_ready=1.
- BOOT:
  - imem_req=0; lasts exactly one cycle after reset release, then goes to FETCH.
  - A redirect in BOOT loads pc<=tgt.
- FETCH: imem_req=1.
  - redir & imem_ready: valid_f=0 (response discarded), pc<=tgt, stay FETCH.
  - redir & ~imem_ready: tgt_q<=tgt, go DRAIN; pc unchanged.
  - ~redir & imem_ready & ~stall_f: valid_f=1, pc<=pc+4 (wraps mod 2^32).
  - ~redir & imem_ready & stall_f: valid_f=1, pc held; the same address is re-read next cycle (instruction memory is read-only, so re-reads are harmless).
  - ~imem_ready: valid_f=0, hold.
- DRAIN: imem_req=1, imem_addr=old pc, valid_f=0 always.
  - A new redir overwrites tgt_q; the latest request wins.
  - On imem_ready: pc<=(redir ? tgt : tgt_q), go FETCH.
- Redirect overrides stall_f. IF/ID loads only when valid_f & ~stall_f & ~flush_d.
- Throughput: with imem_ready tied high, one instruction per cycle, no bubbles except the redirect cycle.
- rst mid-access: the outstanding request is abandoned and imem_req drops immediately. The memory must tolerate an abandoned request.

Test Plan:
- Reset release, imem_ready=1 constant, no redirects:
  - cycle 0: imem_req=0
  - then addresses 0x0, 0x4, 0x8… with valid_f=1 each cycle
- imem_ready=1 at pc=0x10 with branch_e=1, branch_target=0x100, and jal_d=1, jal_target=0x200 in the same cycle:
  - flush_d=1, flush_e=1, valid_f=0
  - next imem_addr=0x100
- imem_ready low for 3 cycles at pc=0x20; jalr_e=1, jalr_target=0x80 on cycle 1:
  - imem_addr stays 0x20 through the cycle with imem_ready=1
  - valid_f=0 throughout
  - then imem_addr=0x80
- stall_f=1 for 2 cycles at pc=0x8 with imem_ready=1:
  - valid_f=1 and imem_addr=0x8 held
  - on stall release, pc advances to 0xC
- jal_d=1, jal_target=0x42:
  - flush_d=1, flush_e=0
  - next imem_addr=0x40, misalign=1 and stays set until rst
- Wrap and mid-access reset:
  - pc=0xFFFF_FFFC, accept → pc=0x0
  - rst asserted while imem_ready=0 → imem_req=0 immediately
  - after release, first request is at RESET_PC
